if_id_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the main decoder.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched instruction into IF/ID; id_instr[6:0] is the decoder's Opcode input.
- Performs load-use hazard detection (stall) and branch redirect (flush) for the 5-stage RV32I subset: R-type, I-type ALU, LW, SW, BEQ, LUI.

---
 rtl/if_id_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//
// Instruction-fetch stage and IF/ID pipeline register for a 5-stage RV32I
// subset pipeline (R-type, I-type ALU, LW, SW, BEQ, LUI). It sits directly
// upstream of the main decoder. id_instr[6:0] is the decoder's opcode input.
//
// The block owns the program counter and drives the instruction-memory
// address from it. It captures the fetched word into IF/ID. It also resolves
// two pipeline hazards:
//   - load-use: the instruction in ID reads a register that the load in
//     ID/EX has not yet produced. IF and IF/ID hold for one cycle, and
//     id_bubble tells ID/EX to capture all-zero control.
//   - taken branch: EX redirects the PC and the IF/ID contents are
//     discarded. The ID/EX flush is handled downstream.
//
// Ports
//   clk            in   1      rising-edge clock
//   reset          in   1      asynchronous, active-low reset
//   instr_addr     out  PC_W   instruction-memory address (current PC)
//   instr_rdata    in   INS_W  instruction at instr_addr (same-cycle read)
//   branch_taken   in   1      EX resolved a taken branch this cycle
//   branch_target  in   PC_W   redirect address, valid with branch_taken
//   ex_mem_read    in   1      MemRead of the instruction in ID/EX
//   ex_rd          in   5      destination register of the instruction in ID/EX
//   id_pc          out  PC_W   PC of the instruction in ID
//   id_instr       out  INS_W  instruction in ID
//   id_valid       out  1      ID holds a real instruction
//   id_bubble      out  1      ID/EX captures zero control this cycle
// -----------------------------------------------------------------------------
module if_id_stage #(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [PC_W-1:0]  instr_addr,
    input  logic [INS_W-1:0] instr_rdata,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    output logic [PC_W-1:0]  id_pc,
    output logic [INS_W-1:0] id_instr,
    output logic             id_valid,
    output logic             id_bubble
);

    // addi x0,x0,0. Loaded on reset and on flush so the decoder always sees
    // a harmless encoding when id_valid is low.
    localparam logic [INS_W-1:0] NOP_INSTR = INS_W'(32'h0000_0013);
    localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(4);

    // Opcodes of the supported subset.
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PC_W-1:0]  pc_q,       pc_d;
    logic [PC_W-1:0]  id_pc_q,    id_pc_d;
    logic [INS_W-1:0] id_instr_q, id_instr_d;
    logic             id_valid_q, id_valid_d;

    // -------------------------------------------------------------------------
    // Field decode on the registered ID instruction. Only IF/ID contents feed
    // the hazard logic, so there is no combinational path from instr_rdata to
    // any output.
    // -------------------------------------------------------------------------
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       uses_rs1;
    logic       uses_rs2;

    assign id_opcode = id_instr_q[6:0];
    assign id_rs1    = id_instr_q[19:15];
    assign id_rs2    = id_instr_q[24:20];

    // LUI and unknown opcodes read no source register. They must never stall,
    // even when their immediate bits happen to alias rs1/rs2.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            OP_RTYPE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_IALU:   begin uses_rs1 = 1'b1; uses_rs2 = 1'b0; end
            OP_LOAD:   begin uses_rs1 = 1'b1; uses_rs2 = 1'b0; end
            OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            default:   begin uses_rs1 = 1'b0; uses_rs2 = 1'b0; end
        endcase
    end

    // -------------------------------------------------------------------------
    // Load-use detection
    // -------------------------------------------------------------------------
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    assign rs1_hit  = uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = uses_rs2 && (id_rs2 == ex_rd);

    // x0 is never written, so a load targeting it cannot create a dependency.
    // An empty ID slot also cannot depend on anything.
    assign load_use = id_valid_q && ex_mem_read && (ex_rd != 5'd0)
                      && (rs1_hit || rs2_hit);

    // A taken branch kills the instruction in ID. A stall bubble would be
    // redundant and would conflict with the downstream flush.
    assign id_bubble = load_use && !branch_taken;

    // -------------------------------------------------------------------------
    // Next-state selection: flush > stall > advance
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;

        if (branch_taken) begin
            // Redirect. Discard the younger instruction sitting in IF/ID.
            pc_d       = branch_target;
            id_pc_d    = '0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (load_use) begin
            // Hold. The load leaves EX next cycle, so this lasts one cycle.
            pc_d       = pc_q;
            id_pc_d    = id_pc_q;
            id_instr_d = id_instr_q;
            id_valid_d = id_valid_q;
        end else begin
            // Advance. PC wraps modulo 2^PC_W through natural truncation.
            pc_d       = pc_q + PC_STEP;
            id_pc_d    = pc_q;
            id_instr_d = instr_rdata;
            id_valid_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign instr_addr = pc_q;
    assign id_pc      = id_pc_q;
    assign id_instr   = id_instr_q;
    assign id_valid   = id_valid_q;

endmodule
